// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    localparam int PWM_PERIOD_SIZE_DEFAULT = 10;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    // All-ones value of a counter of the given width.
    function automatic logic [31:0] cnt_max(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Capture-side bundle: enable and raw PWM in, measurement results out.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int PERIOD_SIZE = PWM_PERIOD_SIZE_DEFAULT
) ();

    logic                   ena;
    logic                   pwm_in;
    logic [PERIOD_SIZE-1:0] high_o;
    logic [PERIOD_SIZE-1:0] period_o;
    logic                   valid_o;
    logic                   timeout_o;

    modport master (output ena, pwm_in, input high_o, period_o, valid_o, timeout_o);
    modport slave  (input ena, pwm_in, output high_o, period_o, valid_o, timeout_o);

endinterface

// File: rtl/pwm_in_sync.sv
// Input conditioning: 2-flop synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN),
// and rise/fall edge strobes on the conditioned level.
module pwm_in_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

`ifdef PWM_CAPTURE_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic [1:0] sync_q;
    logic       s_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], pwm_in};
    end

    if (FILTER_EN && FILTER_LEN > 0) begin : g_filt
        localparam int CW = $clog2(FILTER_LEN + 1);
        logic          filt;
        logic [CW-1:0] run;

        // Level flips only after FILTER_LEN consecutive samples disagree with it.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                filt <= 1'b0;
                run  <= '0;
            end else if (sync_q[1] == filt) begin
                run <= '0;
            end else if (run == CW'(FILTER_LEN - 1)) begin
                filt <= sync_q[1];
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
        assign s = filt;
    end else begin : g_raw
        assign s = sync_q[1];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) s_d <= 1'b0;
        else        s_d <= s;
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period of pwm_in in clk_in cycles.
// Optional input glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD_SIZE = PWM_PERIOD_SIZE_DEFAULT,
    parameter int FILTER_LEN  = 3
) (
    input  logic          clk_in,
    input  logic          rst_n,
    pwm_capture_if.slave  bus
);

    localparam logic [PERIOD_SIZE-1:0] MAX = PERIOD_SIZE'(cnt_max(PERIOD_SIZE));
    localparam logic [PERIOD_SIZE-1:0] ONE = PERIOD_SIZE'(1);

    state_t                 state, state_nx;
    logic [PERIOD_SIZE-1:0] per_cnt, per_nx;
    logic [PERIOD_SIZE-1:0] hi_cnt, hi_nx;
    logic [PERIOD_SIZE-1:0] high_q, high_nx;
    logic [PERIOD_SIZE-1:0] period_q, period_nx;
    logic                   valid_q, valid_nx;
    logic                   tmo_q, tmo_nx;
    logic                   s, rise, fall;
    logic                   per_sat;

    pwm_in_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pwm_in (bus.pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    function automatic logic [PERIOD_SIZE-1:0] sat_inc(input logic [PERIOD_SIZE-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction

    assign per_sat = (per_cnt == MAX);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            per_cnt  <= per_nx;
            hi_cnt   <= hi_nx;
            high_q   <= high_nx;
            period_q <= period_nx;
            valid_q  <= valid_nx;
            tmo_q    <= tmo_nx;
        end
    end

    // Edges are tested before saturation so a coincident edge always wins.
    always_comb begin
        state_nx  = state;
        per_nx    = sat_inc(per_cnt);
        hi_nx     = hi_cnt;
        high_nx   = high_q;
        period_nx = period_q;
        valid_nx  = 1'b0;
        tmo_nx    = tmo_q;
        if (!bus.ena) begin
            state_nx = IDLE;
            per_nx   = '0;
            hi_nx    = '0;
            tmo_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    per_nx = '0;
                    if (rise) begin
                        state_nx = HIGH;
                        per_nx   = ONE;
                        hi_nx    = ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_nx = LOW;
                    end else if (per_sat) begin
                        period_nx = MAX;
                        high_nx   = s ? MAX : '0;
                        valid_nx  = 1'b1;
                        tmo_nx    = 1'b1;
                        state_nx  = STUCK;
                    end else begin
                        hi_nx = sat_inc(hi_cnt);
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_nx   = hi_cnt;
                        period_nx = per_cnt;
                        valid_nx  = 1'b1;
                        tmo_nx    = 1'b0;
                        per_nx    = ONE;
                        hi_nx     = ONE;
                        state_nx  = HIGH;
                    end else if (per_sat) begin
                        period_nx = MAX;
                        high_nx   = s ? MAX : '0;
                        valid_nx  = 1'b1;
                        tmo_nx    = 1'b1;
                        state_nx  = STUCK;
                    end
                end
                STUCK: begin
                    // Leaving STUCK restarts measurement without publishing.
                    if (rise) begin
                        state_nx = HIGH;
                        per_nx   = ONE;
                        hi_nx    = ONE;
                        tmo_nx   = 1'b0;
                    end else if (fall) begin
                        state_nx = IDLE;
                        per_nx   = '0;
                        hi_nx    = '0;
                        tmo_nx   = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.high_o    = high_q;
    assign bus.period_o  = period_q;
    assign bus.valid_o   = valid_q;
    assign bus.timeout_o = tmo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture against a timestamp-based edge model.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int PS   = PWM_PERIOD_SIZE_DEFAULT;
    localparam int FL   = 3;
    localparam int MAXV = (1 << PS) - 1;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   vcount = 0;
    bit   chk_en = 1'b0;

    pwm_capture_if #(.PERIOD_SIZE(PS)) bus ();

    pwm_capture #(.PERIOD_SIZE(PS), .FILTER_LEN(FL)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: pwm_in history per edge, rising/falling timestamps, and the rules for
    // publish / timeout expressed as timestamp differences.
    logic [FL+2:0] hist;
    int  t, rise_t, fall_t;
    bit  armed, stuck, have_fall, mf, mf_d;
    int  e_high, e_per;
    bit  e_valid, e_tmo;

    task automatic model_step();
        bit s, sd, agree;
        hist = {hist[FL+1:0], bus.pwm_in};
        t++;
`ifdef PWM_CAPTURE_FILTER_EN
        s = mf; sd = mf_d; mf_d = mf;
        agree = 1'b1;
        for (int i = 0; i < FL; i++) if (hist[2+i] == mf) agree = 1'b0;
        if (agree) mf = ~mf;
`else
        s = hist[2]; sd = hist[3]; agree = 1'b0;
`endif
        e_valid = 1'b0;
        if (!bus.ena) begin
            armed = 0; stuck = 0; e_tmo = 0;
        end else if (s && !sd) begin
            if (armed && !stuck && have_fall) begin
                e_valid = 1; e_high = fall_t - rise_t; e_per = t - rise_t; e_tmo = 0;
            end
            if (stuck) e_tmo = 0;
            armed = 1; stuck = 0; have_fall = 0; rise_t = t;
        end else if (!s && sd) begin
            if (stuck) begin
                stuck = 0; armed = 0; e_tmo = 0;
            end else if (armed && !have_fall) begin
                have_fall = 1; fall_t = t;
            end
        end else if (armed && !stuck && (t - rise_t) >= MAXV) begin
            e_valid = 1; e_per = MAXV; e_high = s ? MAXV : 0; e_tmo = 1; stuck = 1;
        end
    endtask

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hist = '0; t = 0; rise_t = 0; fall_t = 0;
            armed = 0; stuck = 0; have_fall = 0; mf = 0; mf_d = 0;
            e_high = 0; e_per = 0; e_valid = 0; e_tmo = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk_in) begin
        if (chk_en && rst_n) begin
            chk("valid", int'(bus.valid_o), int'(e_valid));
            chk("timeout", int'(bus.timeout_o), int'(e_tmo));
            chk("high", int'(bus.high_o), e_high);
            chk("period", int'(bus.period_o), e_per);
            if (bus.valid_o) vcount++;
        end
    end

    task automatic drive(input bit v, input int n);
        bus.pwm_in = v;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pwm(input int hi, input int lo, input int cnt);
        repeat (cnt) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        int hi, lo;
        bus.ena    = 1'b1;
        bus.pwm_in = 1'b0;
        #12;
        chk("rst_high", int'(bus.high_o), 0);
        chk("rst_period", int'(bus.period_o), 0);
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_timeout", int'(bus.timeout_o), 0);
        @(posedge clk_in); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        drive(1'b0, 5);

        // generator-like waveform
        vcount = 0;
        pwm(64, 192, 4);
        chk("gen_pulses", vcount, 3);
        chk("gen_high", int'(bus.high_o), 64);
        chk("gen_period", int'(bus.period_o), 256);

        // minimum duty, then stuck high
        pwm(1, 255, 3);
        chk("min_duty_high", int'(bus.high_o), 1);
        drive(1'b1, 1100);
        chk("stuck_hi_tmo", int'(bus.timeout_o), 1);
        chk("stuck_hi_high", int'(bus.high_o), MAXV);
        chk("stuck_hi_period", int'(bus.period_o), MAXV);
        drive(1'b0, 10);
        chk("stuck_hi_clear", int'(bus.timeout_o), 0);

        // stuck low inside LOW, then recovery
        drive(1'b1, 50);
        drive(1'b0, 1100);
        chk("stuck_lo_tmo", int'(bus.timeout_o), 1);
        chk("stuck_lo_high", int'(bus.high_o), 0);
        chk("stuck_lo_period", int'(bus.period_o), MAXV);
        pwm(30, 70, 3);
        chk("recover_tmo", int'(bus.timeout_o), 0);
        chk("recover_high", int'(bus.high_o), 30);
        chk("recover_period", int'(bus.period_o), 100);

        // async reset in mid-HIGH
        drive(1'b1, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_high", int'(bus.high_o), 0);
        chk("arst_period", int'(bus.period_o), 0);
        chk("arst_valid", int'(bus.valid_o), 0);
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_n = 1'b1;
        drive(1'b1, 20);
        drive(1'b0, 60);
        pwm(40, 60, 3);
        chk("post_rst_high", int'(bus.high_o), 40);
        chk("post_rst_period", int'(bus.period_o), 100);

        // enable dropped mid-period
        drive(1'b1, 20);
        vcount = 0;
        bus.ena = 1'b0;
        drive(1'b1, 5);
        drive(1'b0, 5);
        bus.ena = 1'b1;
        chk("ena_no_valid", vcount, 0);
        chk("ena_hold_high", int'(bus.high_o), 40);
        chk("ena_hold_period", int'(bus.period_o), 100);
        pwm(25, 75, 3);
        chk("ena_resume_high", int'(bus.high_o), 25);

        // 2-cycle glitch inside LOW
        pwm(64, 192, 2);
        drive(1'b1, 64);
        drive(1'b0, 100);
        drive(1'b1, 2);
        drive(1'b0, 90);
        drive(1'b1, 10);
`ifdef PWM_CAPTURE_FILTER_EN
        chk("glitch_period", int'(bus.period_o), 256);
`else
        chk("glitch_period", int'(bus.period_o), 92);
`endif
        drive(1'b0, 50);

        // randomized waveforms with occasional enable drops and stuck phases
        for (int k = 0; k < 60; k++) begin
            hi = $urandom_range(1, 300);
            lo = $urandom_range(1, 300);
            if ($urandom_range(0, 14) == 0) hi = 1030;
            if ($urandom_range(0, 14) == 0) lo = 1030;
            drive(1'b1, hi);
            if ($urandom_range(0, 9) == 0) begin
                bus.ena = 1'b0;
                drive(1'b0, $urandom_range(1, 20));
                bus.ena = 1'b1;
            end
            drive(1'b0, lo);
        end
        drive(1'b0, 20);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
